motion_arbiter: RTL
===================

# motion_arbiter

Per-frame ball-motion controller in front of the game engine. Detects the start of each video frame from the scan coordinates and arbitrates ownership of the single ball-motion path among three requesters: accelerometer, mouse and direction buttons. Once per frame it emits one signed step (dx, dy) to the engine through a valid/ready handshake. Mouse deltas are accumulated between frames, and frames the engine cannot absorb are flagged.

## Interface
- SCREEN_WIDTH, 800, horizontal resolution; sets the i_screen_x width
- SCREEN_HEIGHT, 600, vertical resolution; sets the i_screen_y width
- HOLD_FRAMES, 60, consecutive idle frames before a non-button owner is released (1..255)
- DEADZONE, 4, accel activity threshold on |dx| or |dy| (0..127)
- BTN_STEP, 4, step magnitude per pressed button axis (1..255)

- clk  in  1  system clock
- rst  in  1  reset; **synchronous, active-high**
- i_screen_x  in  $clog2(SCREEN_WIDTH)  current scan column
- i_screen_y  in  $clog2(SCREEN_HEIGHT)  current scan row
- i_accel_dx, i_accel_dy  in  8 each  signed accel tilt
- i_mouse_dx, i_mouse_dy  in  9 each  signed mouse delta; qualified by i_mouse_valid
- i_mouse_valid  in  1  one-cycle mouse packet strobe
- i_btn_left, i_btn_right, i_btn_up, i_btn_down  in  1 each  debounced levels
- i_mode  in  2  00 auto, 01 force accel, 10 force mouse, 11 force buttons
- i_step_ready  in  1  engine accepts step
- o_frame_tick  out  1  one-cycle frame-start pulse
- o_step_valid  out  1  step pending
- o_step_dx, o_step_dy  out  9 each  signed step
- o_owner  out  2  0 none, 1 accel, 2 mouse, 3 buttons
- o_overrun  out  1  one-cycle pulse; frame dropped because previous step was not accepted

## Operation
- **Frame detect:** cycle C is a frame-start cycle when (x, y) == (0, 0) and (x, y) was not (0, 0) in C-1. Coordinates held for several clocks produce a single detect.
- **Mouse accumulator:** 9-bit signed per axis, saturating to [-255, +255].
  - Each i_mouse_valid adds the delta.
  - At an accepted frame-start the snapshot equals acc plus any same-cycle delta, saturated. acc is then cleared to 0.
- **Activity, evaluated at C:**
  - accel: |dx| > DEADZONE or |dy| > DEADZONE.
  - mouse: snapshot ≠ (0, 0).
  - buttons: any button pressed.
- **Step source:**
  - buttons: dx = (right - left) * BTN_STEP, dy = (down - up) * BTN_STEP. Opposing presses cancel to 0.
  - accel: sign-extended raw values.
  - mouse: the snapshot.
  - none: (0, 0).
- **Arbitration, auto mode, per accepted frame:**
  - Owner active: keep owner, idle_cnt = 0.
  - Else, buttons active and owner ≠ buttons: owner = buttons, idle_cnt = 0 (buttons always preempt).
  - Else idle_cnt increments, saturating at 255. When idle_cnt reaches HOLD_FRAMES:
    - owner = mouse if mouse active, else accel if accel active, else none.
    - idle_cnt = 0.
- **Forced modes:** owner = forced source every frame, even when that source is inactive; idle_cnt = 0. Returning to auto resumes from the forced owner.
- **FSM:**
  - IDLE: on frame-start, register samples and go to COMPUTE.
  - COMPUTE: one cycle; updates owner and idle_cnt and loads the step registers; go to VALID.
  - VALID: hold o_step_valid and step values stable until i_step_ready, then go to IDLE.
- **Overrun:** frame-start while in COMPUTE or VALID means no sample and no arbitration update. o_overrun pulses and the mouse accumulator is not cleared, so deltas carry into the next accepted frame.
- An owner change takes effect on the step of the same frame.

## Timing
- **Frame-start at C:**
  - o_frame_tick high in C+1 only.
  - COMPUTE in C+1.
  - o_step_valid, step values and new o_owner registered and visible from C+2.
- **Handshake:** valid and ready both high in cycle K means o_step_valid is low in K+1. Minimum latency from detect to accept is 2 cycles, with ready held high.
- o_step_valid never drops without acceptance. Step values never change while o_step_valid is high.
- o_overrun pulses in C+1 for a dropped frame. o_frame_tick still pulses in C+1.
- **Reset:**
  - All outputs 0, o_owner = none, FSM in IDLE, idle_cnt = 0, accumulator 0, frame-detect history cleared.
  - Reset mid-handshake drops the pending step.
  - The first (0, 0) cycle after reset counts as a frame-start.

## Test plan
- **Auto, buttons:** reset, auto mode, right pressed, frame-start, ready = 1 → tick in C+1, step (4, 0) valid in C+2, owner 3, valid low one cycle after accept.
- **Mouse accumulation:** three valid packets dx = +200 within a frame → saturated step dx = +255, owner 2. Next frame with no packets → step (0, 0).
- **Sticky hold:** with HOLD_FRAMES = 3, owner mouse, then only accel (20, -10) active → frames 1-2 output (0, 0) with owner 2. Frame 3 switches to owner 1 with step (20, -10).
- **Deadzone/force:** accel (3, -4), DEADZONE = 4, auto → owner stays none. Set i_mode = 01 → owner 1, step (3, -4).
- **Overrun:** hold ready = 0 across two frame-starts; mouse +5 sent between them → o_overrun pulses on the second, first step held stable. Release ready; the next frame step includes the +5.
- **Reset mid-VALID:** assert rst while o_step_valid = 1 → all outputs 0 next cycle, no step produced until a new frame-start.

Source files
------------

// File: rtl/motion_arbiter.sv
// motion_arbiter: per-frame arbitration of accel/mouse/button motion into one valid/ready step stream
module motion_arbiter #(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int HOLD_FRAMES   = 60,
  parameter int DEADZONE      = 4,
  parameter int BTN_STEP      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_screen_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_screen_y,
  input  logic [7:0]                       i_accel_dx,
  input  logic [7:0]                       i_accel_dy,
  input  logic [8:0]                       i_mouse_dx,
  input  logic [8:0]                       i_mouse_dy,
  input  logic                             i_mouse_valid,
  input  logic                             i_btn_left,
  input  logic                             i_btn_right,
  input  logic                             i_btn_up,
  input  logic                             i_btn_down,
  input  logic [1:0]                       i_mode,
  input  logic                             i_step_ready,
  output logic                             o_frame_tick,
  output logic                             o_step_valid,
  output logic [8:0]                       o_step_dx,
  output logic [8:0]                       o_step_dy,
  output logic [1:0]                       o_owner,
  output logic                             o_overrun
);
  typedef enum logic [1:0] {IDLE, COMPUTE, VALID} state_t;
  state_t state_q, state_d;
  logic prev_zero_q, tick_q, ovr_q;
  logic [8:0] acc_x_q, acc_y_q, acc_x_d, acc_y_d, sum_x, sum_y, snap_x_q, snap_y_q;
  logic [7:0] adx_q, ady_q, mag_x, mag_y, idle_q, idle_d, idle_inc;
  logic [3:0] btn_q;
  logic [1:0] mode_q, owner_q, owner_d;
  logic [8:0] dx_q, dy_q, dx_d, dy_d, btn_dx, btn_dy;
  logic at_zero, frame_start, take, act_a, act_m, act_b, owner_act, preempt, hold_done;

  function automatic logic [8:0] sat_add(input logic [8:0] a, input logic [8:0] b);
    logic signed [9:0] s;
    s = $signed({a[8], a}) + $signed({b[8], b});
    return (s > 10'sd255) ? 9'd255 : (s < -10'sd255) ? 9'h101 : s[8:0];
  endfunction

  assign at_zero     = (i_screen_x == '0) && (i_screen_y == '0);
  assign frame_start = at_zero && !prev_zero_q;
  assign take        = frame_start && (state_q == IDLE);
  assign sum_x       = sat_add(acc_x_q, i_mouse_valid ? i_mouse_dx : 9'd0);
  assign sum_y       = sat_add(acc_y_q, i_mouse_valid ? i_mouse_dy : 9'd0);

  // btn_q = {left, right, up, down}
  assign mag_x     = adx_q[7] ? -adx_q : adx_q;
  assign mag_y     = ady_q[7] ? -ady_q : ady_q;
  assign act_a     = (mag_x > 8'(DEADZONE)) || (mag_y > 8'(DEADZONE));
  assign act_m     = (snap_x_q != '0) || (snap_y_q != '0);
  assign act_b     = |btn_q;
  assign owner_act = (owner_q == 2'd1) ? act_a : (owner_q == 2'd2) ? act_m : (owner_q == 2'd3) ? act_b : 1'b0;
  assign preempt   = act_b && (owner_q != 2'd3);
  assign idle_inc  = (idle_q == 8'hff) ? idle_q : idle_q + 8'd1;
  assign hold_done = idle_inc == 8'(HOLD_FRAMES);
  assign btn_dx    = (btn_q[3] == btn_q[2]) ? 9'd0 : btn_q[2] ? 9'(BTN_STEP) : -9'(BTN_STEP);
  assign btn_dy    = (btn_q[1] == btn_q[0]) ? 9'd0 : btn_q[0] ? 9'(BTN_STEP) : -9'(BTN_STEP);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    idle_d  = idle_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    acc_x_d = take ? 9'd0 : sum_x;
    acc_y_d = take ? 9'd0 : sum_y;
    case (state_q)
      IDLE:    state_d = take ? COMPUTE : IDLE;
      COMPUTE: begin
        state_d = VALID;
        owner_d = (mode_q != 2'd0) ? mode_q : owner_act ? owner_q : preempt ? 2'd3 :
                  hold_done ? (act_m ? 2'd2 : act_a ? 2'd1 : 2'd0) : owner_q;
        idle_d  = ((mode_q != 2'd0) || owner_act || preempt || hold_done) ? 8'd0 : idle_inc;
        dx_d    = (owner_d == 2'd1) ? {adx_q[7], adx_q} : (owner_d == 2'd2) ? snap_x_q : (owner_d == 2'd3) ? btn_dx : 9'd0;
        dy_d    = (owner_d == 2'd1) ? {ady_q[7], ady_q} : (owner_d == 2'd2) ? snap_y_q : (owner_d == 2'd3) ? btn_dy : 9'd0;
      end
      VALID:   state_d = i_step_ready ? IDLE : VALID;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_zero_q <= 1'b0;
      tick_q      <= 1'b0;
      ovr_q       <= 1'b0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      snap_x_q    <= '0;
      snap_y_q    <= '0;
      adx_q       <= '0;
      ady_q       <= '0;
      btn_q       <= '0;
      mode_q      <= '0;
      owner_q     <= '0;
      idle_q      <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
    end else begin
      state_q     <= state_d;
      prev_zero_q <= at_zero;
      tick_q      <= frame_start;
      ovr_q       <= frame_start && (state_q != IDLE);
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      owner_q     <= owner_d;
      idle_q      <= idle_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      if (take) begin
        snap_x_q <= sum_x;
        snap_y_q <= sum_y;
        adx_q    <= i_accel_dx;
        ady_q    <= i_accel_dy;
        btn_q    <= {i_btn_left, i_btn_right, i_btn_up, i_btn_down};
        mode_q   <= i_mode;
      end
    end
  end

  assign o_frame_tick = tick_q;
  assign o_step_valid = state_q == VALID;
  assign o_step_dx    = dx_q;
  assign o_step_dy    = dy_q;
  assign o_owner      = owner_q;
  assign o_overrun    = ovr_q;
endmodule
